// File: rtl/if_skid_stage_reg.sv
// if_skid_stage_reg
// -----------------
// Elastic fetch->decode stage register. It carries a {pc, instruction} beat
// under a valid/ready handshake. A two-entry skid buffer keeps in_ready free of
// any combinational path from out_ready.
//   freeze : hazard stall. Holds all state and blocks both handshakes.
//   flush  : taken branch. Empties the stage and drops any beat offered that
//            cycle. The output becomes a NOP bubble.
//
// Ports
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   freeze, flush       : stall / discard controls
//   in_valid, in_ready  : upstream handshake
//   in_pc, in_instr     : upstream beat
//   out_valid, out_ready: downstream handshake
//   out_pc, out_instr   : main (oldest) entry
//   occupancy           : number of held beats (0, 1 or 2)
module if_skid_stage_reg #(
  parameter int                 PC_W      = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
  parameter logic [PC_W-1:0]    RESET_PC  = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [1:0]         occupancy
);

  // The encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_out_valid;
  logic [PC_W-1:0]    r_main_pc;
  logic [INSTR_W-1:0] r_main_instr;
  logic [PC_W-1:0]    r_skid_pc;
  logic [INSTR_W-1:0] r_skid_instr;

  logic w_in_ready;
  logic w_push;
  logic w_pop;

  // in_ready depends only on registered state and freeze.
  assign w_in_ready = (r_state != S_FULL) & ~freeze;
  assign w_push     = in_valid & w_in_ready & ~flush;
  assign w_pop      = r_out_valid & out_ready & ~freeze & ~flush;

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_pc    = r_main_pc;
  assign out_instr = r_main_instr;
  assign occupancy = r_state;

  // While frozen, w_push and w_pop are both low. The case below therefore
  // leaves every register untouched without a separate freeze branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_EMPTY;
      r_out_valid  <= 1'b0;
      r_main_pc    <= RESET_PC;
      r_main_instr <= NOP_INSTR;
      r_skid_pc    <= RESET_PC;
      r_skid_instr <= NOP_INSTR;
    end else if (flush) begin
      // out_pc keeps its last value. Only the instruction becomes a bubble.
      r_state      <= S_EMPTY;
      r_out_valid  <= 1'b0;
      r_main_instr <= NOP_INSTR;
      r_skid_instr <= NOP_INSTR;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_push) begin
            r_main_pc    <= in_pc;
            r_main_instr <= in_instr;
            r_out_valid  <= 1'b1;
            r_state      <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_push && w_pop) begin
            r_main_pc    <= in_pc;
            r_main_instr <= in_instr;
          end else if (w_push) begin
            r_skid_pc    <= in_pc;
            r_skid_instr <= in_instr;
            r_state      <= S_FULL;
          end else if (w_pop) begin
            r_main_instr <= NOP_INSTR;
            r_out_valid  <= 1'b0;
            r_state      <= S_EMPTY;
          end
        end
        S_FULL: begin
          // in_ready is low here, so only a pop can happen.
          if (w_pop) begin
            r_main_pc    <= r_skid_pc;
            r_main_instr <= r_skid_instr;
            r_state      <= S_ONE;
          end
        end
        default: begin
          r_state     <= S_EMPTY;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_skid_stage_reg.sv
module tb_if_skid_stage_reg;

  localparam int          PC_W      = 32;
  localparam int          INSTR_W   = 32;
  localparam logic [31:0] NOP       = 32'h0;
  localparam logic [31:0] RST_PC    = 32'h0;

  logic               clk = 1'b0;
  logic               rst;
  logic               freeze, flush, in_valid, out_ready;
  logic [PC_W-1:0]    in_pc;
  logic [INSTR_W-1:0] in_instr;
  logic               in_ready, out_valid;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instr;
  logic [1:0]         occupancy;

  int n_tests = 0;
  int n_fail  = 0;

  if_skid_stage_reg #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP), .RESET_PC(RST_PC)
  ) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Observation bundle: {in_ready, out_valid, occupancy, out_pc, out_instr}
  function automatic logic [67:0] obs();
    return {in_ready, out_valid, occupancy, out_pc, out_instr};
  endfunction

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got rdy=%b vld=%b occ=%0d pc=%h instr=%h, want rdy=%b vld=%b occ=%0d pc=%h instr=%h",
               name, act[67], act[66], act[65:64], act[63:32], act[31:0],
               exp[67], exp[66], exp[65:64], exp[63:32], exp[31:0]);
    end
  endtask

  // ---------------- behavioural reference: a bounded FIFO of beats ----------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } beat_t;

  beat_t       mq[$];
  logic [31:0] m_hold_pc;

  function automatic logic [67:0] model_obs(input logic fz);
    logic [31:0] pc, ins;
    pc  = (mq.size() > 0) ? mq[0].pc    : m_hold_pc;
    ins = (mq.size() > 0) ? mq[0].instr : NOP;
    return {(!fz && mq.size() < 2), (mq.size() > 0), 2'(mq.size()), pc, ins};
  endfunction

  task automatic model_step(input logic fz, input logic fl, input logic iv,
                            input logic ordy, input logic [31:0] pc, input logic [31:0] ins);
    bit rdy, psh, pp;
    beat_t b;
    rdy = !fz && (mq.size() < 2);
    psh = iv && rdy && !fl;
    pp  = (mq.size() > 0) && ordy && !fz && !fl;
    if (mq.size() > 0) m_hold_pc = mq[0].pc;
    if (fl) mq.delete();
    else begin
      if (pp) void'(mq.pop_front());
      if (psh) begin
        b.pc = pc; b.instr = ins;
        mq.push_back(b);
      end
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        fz, fl, iv;
    logic [31:0] pc, ins;
    logic        ordy;
    logic        e_vld;
    logic [1:0]  e_occ;
    logic [31:0] e_pc, e_ins;
    logic        e_rdy;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic fz, logic fl, logic iv, logic [31:0] pc, logic [31:0] ins,
                              logic ordy, logic ev, logic [1:0] eo, logic [31:0] ep,
                              logic [31:0] ei, logic er);
    vec_t v;
    v.fz = fz; v.fl = fl; v.iv = iv; v.pc = pc; v.ins = ins; v.ordy = ordy;
    v.e_vld = ev; v.e_occ = eo; v.e_pc = ep; v.e_ins = ei; v.e_rdy = er;
    return v;
  endfunction

  task automatic drive(input logic fz, input logic fl, input logic iv,
                       input logic [31:0] pc, input logic [31:0] ins, input logic ordy);
    freeze = fz; flush = fl; in_valid = iv; in_pc = pc; in_instr = ins; out_ready = ordy;
  endtask

  initial begin
    // streaming
    vt.push_back(mk(0,0,1,32'h00,32'hA,1, 1,1,32'h00,32'hA,1));
    vt.push_back(mk(0,0,1,32'h04,32'hB,1, 1,1,32'h04,32'hB,1));
    vt.push_back(mk(0,0,1,32'h08,32'hC,1, 1,1,32'h08,32'hC,1));
    vt.push_back(mk(0,0,0,32'h00,32'h0,1, 0,0,32'h08,NOP,1));
    // backpressure
    vt.push_back(mk(0,0,1,32'h10,32'h1,0, 1,1,32'h10,32'h1,1));
    vt.push_back(mk(0,0,1,32'h14,32'h2,0, 1,2,32'h10,32'h1,0));
    vt.push_back(mk(0,0,1,32'h18,32'h3,0, 1,2,32'h10,32'h1,0));
    vt.push_back(mk(0,0,1,32'h18,32'h3,1, 1,1,32'h14,32'h2,1));
    vt.push_back(mk(0,0,1,32'h18,32'h3,1, 1,1,32'h18,32'h3,1));
    vt.push_back(mk(0,0,0,32'h00,32'h0,1, 0,0,32'h18,NOP,1));
    // freeze with occupancy 1
    vt.push_back(mk(0,0,1,32'h20,32'h4,0, 1,1,32'h20,32'h4,1));
    vt.push_back(mk(1,0,1,32'h24,32'h5,1, 1,1,32'h20,32'h4,0));
    vt.push_back(mk(1,0,1,32'h24,32'h5,1, 1,1,32'h20,32'h4,0));
    vt.push_back(mk(1,0,1,32'h24,32'h5,1, 1,1,32'h20,32'h4,0));
    vt.push_back(mk(0,0,0,32'h00,32'h0,1, 0,0,32'h20,NOP,1));
    // flush + freeze + in_valid with occupancy 2
    vt.push_back(mk(0,0,1,32'h30,32'h6,0, 1,1,32'h30,32'h6,1));
    vt.push_back(mk(0,0,1,32'h34,32'h7,0, 1,2,32'h30,32'h6,0));
    vt.push_back(mk(1,1,1,32'h38,32'h8,1, 0,0,32'h30,NOP,0));
    vt.push_back(mk(0,0,0,32'h00,32'h0,1, 0,0,32'h30,NOP,1));
    // flush while empty drops the offered beat; next beat accepted
    vt.push_back(mk(0,1,1,32'h40,32'h9,1, 0,0,32'h30,NOP,1));
    vt.push_back(mk(0,0,1,32'h44,32'hA,1, 1,1,32'h44,32'hA,1));
    vt.push_back(mk(0,0,0,32'h00,32'h0,1, 0,0,32'h44,NOP,1));
  end

  initial begin
    rst = 1'b1;
    drive(0,0,0,32'h0,32'h0,0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", obs(), {1'b1, 1'b0, 2'd0, RST_PC, NOP});
    rst = 1'b0;
    #1;
    check("reset_release", obs(), {1'b1, 1'b0, 2'd0, RST_PC, NOP});

    // ---- table ----
    @(negedge clk);
    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].fz, vt[i].fl, vt[i].iv, vt[i].pc, vt[i].ins, vt[i].ordy);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), obs(),
            {vt[i].e_rdy, vt[i].e_vld, vt[i].e_occ, vt[i].e_pc, vt[i].e_ins});
    end

    // ---- async reset mid-cycle with two beats held ----
    drive(0,0,1,32'h50,32'h11,0);
    @(posedge clk); #1;
    drive(0,0,1,32'h54,32'h12,0);
    @(posedge clk); #1;
    drive(0,0,0,32'h0,32'h0,0);
    check("pre_rst_full", obs(), {1'b0, 1'b1, 2'd2, 32'h50, 32'h11});
    #2 rst = 1'b1;
    #1;
    check("async_rst", obs(), {1'b1, 1'b0, 2'd0, RST_PC, NOP});
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst", obs(), {1'b1, 1'b0, 2'd0, RST_PC, NOP});

    // ---- randomized run against the FIFO model ----
    mq.delete();
    m_hold_pc = RST_PC;
    @(posedge clk); #1;
    for (int c = 0; c < 3000; c++) begin
      logic fz, fl, iv, ordy;
      logic [31:0] pc, ins;
      fz   = ($urandom_range(7)  == 0);
      fl   = ($urandom_range(15) == 0);
      iv   = ($urandom_range(3)  != 0);
      ordy = ($urandom_range(1)  == 0);
      pc   = $urandom;
      ins  = $urandom;
      drive(fz, fl, iv, pc, ins, ordy);
      #2;
      check($sformatf("rand%0d", c), obs(), model_obs(fz));
      @(posedge clk);
      model_step(fz, fl, iv, ordy, pc, ins);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
